// File: rtl/if_stage.sv
// if_stage: instruction fetch with a single-word bus-master FSM and the IF/ID register.
module if_stage #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0] NOP_INSN = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              busy,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);
  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;
  state_t state;
  logic [DATA_W-1:0] latch, insn;
  logic [ADDR_W-1:0] fa, next_fa;
  assign bus_rw = 1'b1;
  assign bus_wr_data = '0;
  assign busy = !reset && !flush && (state == IDLE || state == REQ || (state == ACCESS && bus_rdy_));
  always_comb begin
    insn = state == STALL ? latch : bus_rd_data;
    next_fa = flush ? new_pc : br_taken ? br_addr : fa + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus_req_ <= 1'b1;
      bus_as_ <= 1'b1;
      bus_addr <= '0;
      latch <= '0;
    end else
      case (state)
        IDLE:
          if (!flush) begin
            bus_req_ <= 1'b0;
            bus_addr <= fa;
            state <= REQ;
          end
        REQ:
          if (flush) begin
            bus_req_ <= 1'b1;
            state <= IDLE;
          end else if (!bus_grnt_) begin
            bus_as_ <= 1'b0;
            state <= ACCESS;
          end
        ACCESS: begin
          bus_as_ <= 1'b1;
          if (flush) begin
            bus_req_ <= 1'b1;
            state <= IDLE;
          end else if (!bus_rdy_) begin
            latch <= bus_rd_data;
            bus_req_ <= 1'b1;
            state <= stall ? STALL : IDLE;
          end
        end
        default: if (flush || !stall) state <= IDLE;
      endcase
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fa <= RESET_VECTOR;
      if_pc <= RESET_VECTOR;
      if_insn <= NOP_INSN;
      if_en <= 1'b0;
    end else if (!stall) begin
      fa <= next_fa;
      if_pc <= next_fa;
      if_insn <= flush ? NOP_INSN : insn;
      if_en <= !flush;
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table-driven fetch vectors plus stall/flush/reset sequences, scoreboarded on IF/ID updates.
module tb_if_stage;
  logic clk = 1'b0, reset = 1'b1, ext_stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
  logic stall, busy, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_, if_en;
  logic [29:0] new_pc = '0, br_addr = '0, bus_addr, if_pc;
  logic [31:0] bus_wr_data, bus_rd_data, if_insn;
  int checks = 0, failures = 0;
  int gw = 0, rw = 0, gcnt = 0, cnt = 0;
  logic act = 1'b0;
  typedef struct {logic [29:0] pc; logic [31:0] insn; logic en;} exp_t;
  typedef struct {int g; int r; logic br; logic [29:0] ba; logic [29:0] addr; logic [29:0] pc; logic [31:0] insn; int cyc;} vec_t;
  exp_t sb[$];
  exp_t me;
  vec_t tbl[10];

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .busy(busy), .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_addr(bus_addr), .bus_rw(bus_rw),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
    .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en)
  );

  always #5 clk = ~clk;

  // controller folds busy into the global stall; memory word n holds 32'h1000+n
  assign stall = ext_stall | busy;
  assign bus_grnt_ = !(!bus_req_ && gcnt >= gw);
  assign bus_rdy_ = !(!bus_req_ && ((!bus_as_ && rw == 0) || (act && cnt >= rw)));
  assign bus_rd_data = bus_rdy_ ? 32'hDEADBEEF : 32'h1000 + {2'b0, bus_addr};

  always @(posedge clk) begin
    gcnt <= bus_req_ ? 0 : gcnt + 1;
    if (bus_req_ || !bus_rdy_) act <= 1'b0;
    else if (!bus_as_) begin
      act <= 1'b1;
      cnt <= 1;
    end else if (act) cnt <= cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  always @(posedge clk)
    if (!reset && !stall) begin
      #1;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected IF/ID update: if_pc %h if_insn %h", if_pc, if_insn);
      end else begin
        me = sb.pop_front();
        chk("if_pc", 32'(if_pc), 32'(me.pc));
        chk("if_insn", if_insn, me.insn);
        chk("if_en", 32'(if_en), 32'(me.en));
      end
    end

  task automatic run_fetch(output int cyc, output logic [29:0] addr);
    logic upd;
    cyc = 0;
    addr = '0;
    do begin
      #1;
      upd = !stall;
      addr = bus_addr;
      @(posedge clk);
      cyc++;
      if (!upd) @(negedge clk);
    end while (!upd && cyc < 60);
  endtask

  task automatic flush_seq(input int edges, input logic [29:0] npc, input logic br);
    int cyc;
    logic [29:0] addr;
    gw = 0;
    rw = 3;
    br_taken = br;
    br_addr = 30'h55;
    repeat (edges) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    new_pc = npc;
    sb.push_back(exp_t'{npc, 32'h0, 1'b0});
    #1 chk("flush busy", 32'(busy), 32'h0);
    @(negedge clk);
    flush = 1'b0;
    br_taken = 1'b0;
    #1;
    chk("flush bus_req_", 32'(bus_req_), 32'h1);
    chk("flush bus_as_", 32'(bus_as_), 32'h1);
    rw = 0;
    sb.push_back(exp_t'{npc + 30'h1, 32'h1000 + 32'(npc), 1'b1});
    run_fetch(cyc, addr);
    chk("post-flush cycles", 32'(cyc), 32'd3);
    chk("post-flush bus_addr", 32'(addr), 32'(npc));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [29:0] addr;
    tbl[0] = '{0, 0, 1'b0, 30'h0, 30'h0, 30'h1, 32'h1000, 3};
    tbl[1] = '{0, 0, 1'b0, 30'h0, 30'h1, 30'h2, 32'h1001, 3};
    tbl[2] = '{0, 0, 1'b0, 30'h0, 30'h2, 30'h3, 32'h1002, 3};
    tbl[3] = '{2, 0, 1'b0, 30'h0, 30'h3, 30'h4, 32'h1003, 5};
    tbl[4] = '{0, 4, 1'b0, 30'h0, 30'h4, 30'h5, 32'h1004, 7};
    tbl[5] = '{0, 0, 1'b1, 30'h40, 30'h5, 30'h40, 32'h1005, 3};
    tbl[6] = '{0, 0, 1'b0, 30'h0, 30'h40, 30'h41, 32'h1040, 3};
    tbl[7] = '{1, 2, 1'b1, 30'h3FFFFFFF, 30'h41, 30'h3FFFFFFF, 32'h1041, 6};
    tbl[8] = '{0, 0, 1'b0, 30'h0, 30'h3FFFFFFF, 30'h0, 32'h40000FFF, 3};
    tbl[9] = '{0, 0, 1'b0, 30'h0, 30'h0, 30'h1, 32'h1000, 3};
    repeat (2) @(negedge clk);
    #1;
    chk("reset if_en", 32'(if_en), 32'h0);
    chk("reset if_insn", if_insn, 32'h0);
    chk("reset if_pc", 32'(if_pc), 32'h0);
    chk("reset bus_req_", 32'(bus_req_), 32'h1);
    chk("reset bus_as_", 32'(bus_as_), 32'h1);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset bus_addr", 32'(bus_addr), 32'h0);
    chk("bus_rw", 32'(bus_rw), 32'h1);
    chk("bus_wr_data", bus_wr_data, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      gw = tbl[i].g;
      rw = tbl[i].r;
      br_taken = tbl[i].br;
      br_addr = tbl[i].ba;
      sb.push_back(exp_t'{tbl[i].pc, tbl[i].insn, 1'b1});
      run_fetch(cyc, addr);
      chk($sformatf("row%0d cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      chk($sformatf("row%0d bus_addr", i), 32'(addr), 32'(tbl[i].addr));
      @(negedge clk);
    end
    br_taken = 1'b0;
    gw = 0;
    rw = 2;
    ext_stall = 1'b1;
    sb.push_back(exp_t'{30'h2, 32'h1001, 1'b1});
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    chk("stall bus_req_", 32'(bus_req_), 32'h1);
    chk("stall busy", 32'(busy), 32'h0);
    chk("stall hold if_pc", 32'(if_pc), 32'h1);
    chk("stall hold if_insn", if_insn, 32'h1000);
    ext_stall = 1'b0;
    @(negedge clk);
    rw = 0;
    sb.push_back(exp_t'{30'h3, 32'h1002, 1'b1});
    run_fetch(cyc, addr);
    chk("after-stall cycles", 32'(cyc), 32'd3);
    chk("after-stall bus_addr", 32'(addr), 32'h2);
    @(negedge clk);
    flush_seq(2, 30'h100, 1'b0);
    flush_seq(2, 30'h200, 1'b1);
    flush_seq(1, 30'h3FF, 1'b0);
    gw = 0;
    rw = 5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid-access reset bus_req_", 32'(bus_req_), 32'h1);
    chk("mid-access reset bus_as_", 32'(bus_as_), 32'h1);
    chk("mid-access reset if_pc", 32'(if_pc), 32'h0);
    chk("mid-access reset if_en", 32'(if_en), 32'h0);
    chk("mid-access reset busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rw = 0;
    sb.push_back(exp_t'{30'h1, 32'h1000, 1'b1});
    run_fetch(cyc, addr);
    chk("restart cycles", 32'(cyc), 32'd3);
    chk("restart bus_addr", 32'(addr), 32'h0);
    @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
